isqrt_out_buffer: RTL and testbench
===================================

# isqrt_out_buffer

Output stage of the pipelined integer square-root unit. It sits directly after the last registered sqrt slice and captures each result (root and remainder) into a small FIFO, because the slice pipeline itself cannot stall. It presents the results to the consumer with a valid/ready handshake. It tracks operands in flight and tells the feeder when it may issue, so that a result never arrives at a full buffer.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `W`, 32: data width of `res_x`/`res_y`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (`rst` = 0 resets); released synchronously by the system.
- `issue_vld` in 1: an operand enters the first slice this cycle.
- `issue_ok` out 1: the feeder may assert `issue_vld` this cycle.
- `res_vld` in 1: the last slice's `ovld`.
- `res_x` in W: the last slice's `ox` (remainder).
- `res_y` in W: the last slice's `oy` (root).
- `out_vld` out 1: result available.
- `out_rdy` in 1: the consumer accepts the result.
- `out_x` out W: remainder.
- `out_y` out W: root.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `in_flight` out $clog2(DEPTH)+1: operands issued but not yet returned.
- `err` out 1: sticky protocol-error flag.

## Operation
- **Push:** `res_vld` writes {`res_x`,`res_y`} at `wr_ptr`.
- **Pop:** `out_vld & out_rdy` advances `rd_ptr`.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `level` is tracked by an explicit counter, not by pointer difference.
- **Show-ahead:** `out_vld` = (`level` != 0). `out_x`/`out_y` = mem[`rd_ptr`]. The outputs stay stable while `out_vld & !out_rdy`.
- **in_flight counter:**
  - `issue_vld` alone: +1.
  - `res_vld` alone: −1.
  - Both in the same cycle: unchanged.
- **Admission:** `issue_ok` = (`in_flight` + `level`) < DEPTH, computed from registered state only (no combinational path from inputs).
- **Full with simultaneous pop:** when `level` == DEPTH and a pop happens in the same cycle as `res_vld`, the write is accepted and `level` stays DEPTH.
- **Errors** (each sets `err`; `err` clears only on reset):
  - `issue_vld` while `!issue_ok`: the issue is still counted; `in_flight` saturates at DEPTH.
  - `res_vld` while `in_flight` == 0: the result is still written if space exists; `in_flight` stays 0.
  - `res_vld` while full and no pop: the result is dropped; pointers and `level` are unchanged.
- **Empty FIFO:** `out_rdy` has no effect.
- **Reset values:**
  - `wr_ptr`, `rd_ptr`, `level`, `in_flight` = 0.
  - `err` = 0, `out_vld` = 0, `issue_ok` = 1.
  - The memory is not reset, so `out_x`/`out_y` are don't-care while `!out_vld`.
- **Reset mid-operation:** every in-flight and buffered result is discarded. The slice pipeline clears its valids on the same reset, so no stale `res_vld` follows.

## Timing
- A result with `res_vld` at edge t gives `out_vld` = 1 and valid data after edge t (one-cycle latency). Pop takes effect at the same edge it is sampled.
- `issue_ok` reflects counter updates one cycle after the causing event.
  - With DEPTH issues and no returns, `issue_ok` falls the cycle after the DEPTH-th issue.
- One push and one pop are allowed every cycle, for sustained throughput of 1 result/cycle.
- The feeder may launch at most DEPTH operands without any pop. This holds for any pipeline latency.

## Structure
- Package `isqrt_pkg`:
  - `ISQRT_W` = 32.
  - Default `ISQRT_BUF_DEPTH` = 8.
  - Typedef `isqrt_res_t` (packed struct {x, y}, W each).
- Sub-module `isqrt_res_fifo`: show-ahead storage, pointers and `level`, with push/pop/full/empty.
- The top level adds the `in_flight` counter, the admission logic and `err`.

## Test plan
- **Reset:** assert `rst` = 0 mid-stream with `level` = 3 and `in_flight` = 2 → immediately `out_vld` = 0, `issue_ok` = 1, `level` = 0, `in_flight` = 0, `err` = 0.
- **Single result:** `issue_vld` at cycle 0; `res_vld` with y = 0x0000_0003, x = 0x0000_0000 at cycle 16 → `out_vld` = 1 at cycle 17 with `out_y` = 3; `in_flight` returns to 0; pop with `out_rdy` = 1 → `out_vld` = 0.
- **Fill / backpressure** (DEPTH = 8, `out_rdy` = 0): issue 8 consecutive operands → `issue_ok` = 0 from cycle 8. All 8 returned results → `level` = 8 and `issue_ok` stays 0. One pop → `issue_ok` = 1 on the next cycle. Output order matches issue order.
- **Full with simultaneous push/pop:** `level` = 8, `res_vld` and `out_rdy` in the same cycle → `level` stays 8, no `err`, the new entry is read out last.
- **Errors:** `res_vld` with `in_flight` = 0 → `err` = 1. Push while full without pop → entry dropped and `level` unchanged. `err` remains 1 until reset.
- **Streaming:** random `out_rdy` at 50%, 200 operands issued whenever `issue_ok` → no drops, `err` = 0, every y/x pair delivered in order.

Source files
------------

// File: rtl/isqrt_pkg.sv
// ---------------------------------------------------------------------------
// isqrt_pkg
// Shared constants and types for the integer square-root output stage.
//   ISQRT_W          : width of one root or remainder word
//   ISQRT_BUF_DEPTH  : default number of result buffer entries
//   isqrt_res_t      : one result as it is stored in the buffer {x, y}
//                      (x = remainder, y = root)
// ---------------------------------------------------------------------------
package isqrt_pkg;

  localparam int ISQRT_W         = 32;
  localparam int ISQRT_BUF_DEPTH = 8;

  typedef struct packed {
    logic [ISQRT_W-1:0] x;
    logic [ISQRT_W-1:0] y;
  } isqrt_res_t;

endpackage

// File: rtl/isqrt_out_buffer_if.sv
// ---------------------------------------------------------------------------
// isqrt_out_buffer_if
// Bundles every signal between the output buffer and its surroundings.
//   issue_vld / issue_ok          : feeder admission handshake
//   res_vld / res_x / res_y       : results from the last sqrt slice
//   out_vld / out_rdy / out_x/_y  : consumer valid/ready handshake
//   level / in_flight / err       : status
// Modports:
//   master : the environment (feeder, slice pipeline, consumer)
//   slave  : the output buffer itself
// ---------------------------------------------------------------------------
interface isqrt_out_buffer_if
  import isqrt_pkg::*;
#(
  parameter int W     = ISQRT_W,
  parameter int DEPTH = ISQRT_BUF_DEPTH
);

  logic                     issue_vld;
  logic                     issue_ok;
  logic                     res_vld;
  logic [W-1:0]             res_x;
  logic [W-1:0]             res_y;
  logic                     out_vld;
  logic                     out_rdy;
  logic [W-1:0]             out_x;
  logic [W-1:0]             out_y;
  logic [$clog2(DEPTH):0]   level;
  logic [$clog2(DEPTH):0]   in_flight;
  logic                     err;

  modport master (
    output issue_vld, res_vld, res_x, res_y, out_rdy,
    input  issue_ok, out_vld, out_x, out_y, level, in_flight, err
  );

  modport slave (
    input  issue_vld, res_vld, res_x, res_y, out_rdy,
    output issue_ok, out_vld, out_x, out_y, level, in_flight, err
  );

endinterface

// File: rtl/isqrt_res_fifo.sv
// ---------------------------------------------------------------------------
// isqrt_res_fifo
// Show-ahead result storage: the entry at rd_ptr is always presented on dout.
//   clk, rst   : clock, asynchronous active-low reset
//   push, din  : write request and data
//   pop        : read request (ignored while empty)
//   dout       : head entry (undefined while empty; memory is not reset)
//   level      : occupancy, kept by its own counter
//   full/empty : occupancy flags
//   push_acc   : the write was accepted this cycle
//   pop_acc    : the head was removed this cycle
// A write into a full buffer is accepted when a pop happens in the same
// cycle, since the popped slot is freed at that same edge.
// ---------------------------------------------------------------------------
module isqrt_res_fifo
  import isqrt_pkg::*;
#(
  parameter int DEPTH = ISQRT_BUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  isqrt_res_t             din,
  input  logic                   pop,
  output isqrt_res_t             dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   push_acc,
  output logic                   pop_acc
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  isqrt_res_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);
  assign dout     = mem[rd_ptr];

  // Storage is written without reset; its content only matters once level
  // says an entry is present.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy moves only when exactly one of push/pop is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/isqrt_out_buffer.sv
// ---------------------------------------------------------------------------
// isqrt_out_buffer
// Output stage of the pipelined integer square-root unit. Captures every
// result leaving the (non-stallable) slice pipeline into a small FIFO and
// hands it to the consumer over valid/ready. Counts operands in flight so
// the feeder is only allowed to issue while in_flight + level < DEPTH,
// which guarantees a returning result always finds a free slot.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : isqrt_out_buffer_if.slave (issue, result, output, status)
// err is sticky and flags: issue while not allowed, a result with nothing
// in flight, and a result dropped because the buffer was full.
// ---------------------------------------------------------------------------
module isqrt_out_buffer
  import isqrt_pkg::*;
#(
  parameter int DEPTH = ISQRT_BUF_DEPTH,
  parameter int W     = ISQRT_W
) (
  input  logic                clk,
  input  logic                rst,
  isqrt_out_buffer_if.slave   bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] IF_MAX  = LW'(DEPTH);
  localparam logic [LW:0]   OCC_MAX = (LW+1)'(DEPTH);

  // The stored result type has a fixed word width.
  if (W != ISQRT_W) begin : g_width_check
    $error("isqrt_out_buffer: W must equal ISQRT_W");
  end

  isqrt_res_t    fifo_din;
  isqrt_res_t    fifo_dout;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          push_acc;
  logic          pop_acc;
  logic [LW-1:0] in_flight;
  logic [LW:0]   occupancy;
  logic          issue_ok;
  logic          err;
  logic          err_set;

  assign fifo_din.x = bus.res_x;
  assign fifo_din.y = bus.res_y;

  isqrt_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.res_vld),
    .din      (fifo_din),
    .pop      (bus.out_rdy),
    .dout     (fifo_dout),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .push_acc (push_acc),
    .pop_acc  (pop_acc)
  );

  // Admission looks only at registered counters, so issue_ok has no
  // combinational path from any input and lags each event by one cycle.
  assign occupancy = {1'b0, in_flight} + {1'b0, level};
  assign issue_ok  = (occupancy < OCC_MAX);

  // An issue and a return in the same cycle cancel out. An over-issue
  // saturates at DEPTH; a return with nothing in flight leaves it at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight <= '0;
    end else if (bus.issue_vld && !bus.res_vld) begin
      if (in_flight != IF_MAX) begin
        in_flight <= in_flight + LW'(1);
      end
    end else if (!bus.issue_vld && bus.res_vld) begin
      if (in_flight != '0) begin
        in_flight <= in_flight - LW'(1);
      end
    end
  end

  // A result not accepted by the FIFO can only mean full without a pop.
  assign err_set = (bus.issue_vld & ~issue_ok)
                 | (bus.res_vld & (in_flight == '0))
                 | (bus.res_vld & ~push_acc);

  // Protocol errors latch until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  assign bus.issue_ok  = issue_ok;
  assign bus.out_vld   = ~empty;
  assign bus.out_x     = fifo_dout.x;
  assign bus.out_y     = fifo_dout.y;
  assign bus.level     = level;
  assign bus.in_flight = in_flight;
  assign bus.err       = err;

endmodule

// File: tb/tb_isqrt_out_buffer.sv
// ---------------------------------------------------------------------------
// tb_isqrt_out_buffer
// Directed bench for isqrt_out_buffer: a vector table for basic push/pop/
// in_flight behaviour, hand-written sequences for latency, fill and
// backpressure, full push+pop, error flags and mid-stream reset, and a
// streaming run with a modelled slice pipeline and random consumer stalls.
// ---------------------------------------------------------------------------
module tb_isqrt_out_buffer;
  import isqrt_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int LAT   = 5;
  localparam int NOPS  = 200;

  typedef struct {
    bit          iv;
    bit          rv;
    logic [31:0] rx;
    logic [31:0] ry;
    bit          rdy;
    bit          e_vld;
    logic [31:0] e_x;
    logic [31:0] e_y;
    int          e_lvl;
    int          e_if;
    bit          e_ok;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  isqrt_out_buffer_if #(.W(W), .DEPTH(DEPTH)) bus ();

  isqrt_out_buffer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(bit iv, bit rv, logic [31:0] rx, logic [31:0] ry,
                                 bit rdy, bit ev, logic [31:0] ex, logic [31:0] ey,
                                 int el, int ei, bit eok);
    vec_t v;
    v.iv = iv; v.rv = rv; v.rx = rx; v.ry = ry; v.rdy = rdy;
    v.e_vld = ev; v.e_x = ex; v.e_y = ey; v.e_lvl = el; v.e_if = ei; v.e_ok = eok;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string name, input bit vld, input int lvl,
                            input int ifl, input bit ok, input bit e);
    checkOutput({name, "_out_vld"},   32'(bus.out_vld),   32'(vld));
    checkOutput({name, "_level"},     32'(bus.level),     32'(lvl));
    checkOutput({name, "_in_flight"}, 32'(bus.in_flight), 32'(ifl));
    checkOutput({name, "_issue_ok"},  32'(bus.issue_ok),  32'(ok));
    checkOutput({name, "_err"},       32'(bus.err),       32'(e));
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 unit later.
  task automatic applyStimulus(input bit iv, input bit rv, input logic [31:0] rx,
                               input logic [31:0] ry, input bit rdy);
    bus.issue_vld = iv;
    bus.res_vld   = rv;
    bus.res_x     = rx;
    bus.res_y     = ry;
    bus.out_rdy   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic doReset();
    bus.issue_vld = 1'b0;
    bus.res_vld   = 1'b0;
    bus.res_x     = '0;
    bus.res_y     = '0;
    bus.out_rdy   = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  vec_t vecs[11];
  int   issued;
  int   rcv;
  int   cyc;
  bit   pv [LAT];
  int   pt [LAT];
  bit   s_iv;
  bit   s_rv;
  bit   s_rdy;
  logic [31:0] s_ry;

  initial begin
    // Basic behaviour table; expectations are the state after each edge.
    vecs[0]  = mkVec(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1, 1'b1);
    vecs[1]  = mkVec(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 2, 1'b1);
    vecs[2]  = mkVec(1'b0, 1'b1, 32'h0, 32'h3, 1'b0, 1'b1, 32'h0, 32'h3, 1, 1, 1'b1);
    vecs[3]  = mkVec(1'b0, 1'b1, 32'h2, 32'h5, 1'b1, 1'b1, 32'h2, 32'h5, 1, 0, 1'b1);
    vecs[4]  = mkVec(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 0, 1'b1);
    vecs[5]  = mkVec(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 0, 1'b1);
    vecs[6]  = mkVec(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1, 1'b1);
    vecs[7]  = mkVec(1'b1, 1'b1, 32'h1, 32'h7, 1'b0, 1'b1, 32'h1, 32'h7, 1, 1, 1'b1);
    vecs[8]  = mkVec(1'b0, 1'b1, 32'h4, 32'h9, 1'b0, 1'b1, 32'h1, 32'h7, 2, 0, 1'b1);
    vecs[9]  = mkVec(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h9, 1, 0, 1'b1);
    vecs[10] = mkVec(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 0, 1'b1);

    // Reset state while reset is held.
    doReset();
    checkState("reset", 1'b0, 0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].rv, vecs[i].rx, vecs[i].ry, vecs[i].rdy);
      checkState($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_lvl, vecs[i].e_if,
                 vecs[i].e_ok, 1'b0);
      if (vecs[i].e_vld) begin
        checkOutput($sformatf("vec%0d_out_x", i), bus.out_x, vecs[i].e_x);
        checkOutput($sformatf("vec%0d_out_y", i), bus.out_y, vecs[i].e_y);
      end
    end

    // Single result with a 16-cycle pipeline.
    $display("[TB] single result");
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(15);
    checkState("single_wait", 1'b0, 0, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h3, 1'b0);
    checkState("single_ret", 1'b1, 1, 0, 1'b1, 1'b0);
    checkOutput("single_out_y", bus.out_y, 32'h3);
    checkOutput("single_out_x", bus.out_x, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkState("single_pop", 1'b0, 0, 0, 1'b1, 1'b0);

    // Fill, backpressure and full push+pop.
    $display("[TB] fill and backpressure");
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput($sformatf("fill_issue_ok%0d", i), 32'(bus.issue_ok), 32'(i < DEPTH - 1));
    end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 32'(i), 32'(100 + i), 1'b0);
      checkOutput($sformatf("fill_ret_ok%0d", i), 32'(bus.issue_ok), 32'h0);
    end
    checkState("fill_full", 1'b1, 8, 0, 1'b0, 1'b0);
    checkOutput("fill_head_y", bus.out_y, 32'd100);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkState("fill_pop1", 1'b1, 7, 0, 1'b1, 1'b0);
    checkOutput("fill_pop1_y", bus.out_y, 32'd101);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    checkState("fill_reissue", 1'b1, 7, 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd8, 32'd108, 1'b0);
    checkState("fill_refull", 1'b1, 8, 0, 1'b0, 1'b0);
    // Over-issue to get a result arriving at a full buffer.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    checkState("over_issue", 1'b1, 8, 1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'd9, 32'd109, 1'b1);
    checkState("full_pushpop", 1'b1, 8, 0, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput($sformatf("drain_y%0d", k), bus.out_y, 32'(102 + k));
      checkOutput($sformatf("drain_x%0d", k), bus.out_x, 32'(2 + k));
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    end
    checkOutput("drain_empty", 32'(bus.out_vld), 32'h0);

    // Error flags: return with nothing in flight, push while full.
    $display("[TB] errors");
    doReset();
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h50, 1'b0);
    checkState("err_noflight", 1'b1, 1, 0, 1'b1, 1'b1);
    for (int i = 1; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 32'(i), 32'(32'h50 + i), 1'b0);
    checkState("err_full", 1'b1, 8, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'hBEEF, 32'hDEAD, 1'b0);
    checkState("err_drop", 1'b1, 8, 0, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput($sformatf("err_drain_y%0d", k), bus.out_y, 32'(32'h50 + k));
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    end
    idle(3);
    checkState("err_sticky", 1'b0, 0, 0, 1'b1, 1'b1);

    // Reset mid-stream with level 3 and in_flight 2.
    $display("[TB] mid-stream reset");
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h0, 32'(i), 1'b0);
    checkState("pre_reset", 1'b1, 3, 2, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkState("async_reset", 1'b0, 0, 0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    checkState("post_reset", 1'b0, 0, 0, 1'b1, 1'b0);

    // Streaming with a modelled slice pipeline and random consumer stalls.
    $display("[TB] streaming");
    doReset();
    issued = 0;
    rcv    = 0;
    cyc    = 0;
    for (int k = 0; k < LAT; k++) begin
      pv[k] = 1'b0;
      pt[k] = 0;
    end
    while (rcv < NOPS && cyc < 5000) begin
      s_rdy = 1'($urandom_range(0, 1));
      if (bus.out_vld && s_rdy) begin
        checkOutput("stream_y", bus.out_y, 32'(rcv));
        checkOutput("stream_x", bus.out_x, 32'(rcv) ^ 32'h5A5A_0000);
        rcv++;
      end
      s_iv = bus.issue_ok && (issued < NOPS);
      s_rv = pv[LAT-1];
      s_ry = 32'(pt[LAT-1]);
      for (int k = LAT - 1; k > 0; k--) begin
        pv[k] = pv[k-1];
        pt[k] = pt[k-1];
      end
      pv[0] = s_iv;
      pt[0] = issued;
      if (s_iv) issued++;
      applyStimulus(s_iv, s_rv, s_ry ^ 32'h5A5A_0000, s_ry, s_rdy);
      cyc++;
    end
    checkOutput("stream_count", 32'(rcv), 32'(NOPS));
    checkState("stream_end", 1'b0, 0, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
